bmem_line_arbiter: RTL and testbench

//  Initiator side of the burst-memory (bmem) interface inside mp4. Arbitrates line requests from I-cache
//  (read-only) and D-cache (read/write). Converts each granted 256-bit line access into one 4-beat x 64-bit

---
 rtl/bmem_pkg.sv | 30 +++
 rtl/bmem_rr_arbiter.sv | 23 ++
 rtl/bmem_line_arbiter.sv | 144 ++++++++++++++
 tb/tb_bmem_line_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the burst-memory line arbiter.
// Line geometry, FSM state encoding and client grant encoding.
package bmem_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = 5;
    localparam int BEAT_CNT_W  = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_WAIT,
        DONE
    } bmem_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } bmem_gnt_t;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/bmem_rr_arbiter.sv
// Two-way round-robin arbiter: on contention the client that did not win last time is granted.
// Purely combinational; grant is one-hot or zero when disabled / no request.
module bmem_rr_arbiter
    import bmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  bmem_gnt_t  last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = (last_grant == GNT_I) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/bmem_line_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one bmem port, one 4-beat burst per line,
// and returns the assembled line with a single-cycle resp to the granted client.
module bmem_line_arbiter
    import bmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    input  logic                  icache_read,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic [ADDR_WIDTH-1:0] bmem_address,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    bmem_state_t           state_q, state_d;
    bmem_gnt_t             last_grant_q, last_grant_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wline_q, wline_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] irdata_q, irdata_d;
    logic [LINE_WIDTH-1:0] drdata_q, drdata_d;
    logic [1:0]            grant;
    logic                  beat_last;

    assign beat_last = (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));

    bmem_rr_arbiter u_rr (
        .req        ({dcache_read | dcache_write, icache_read}),
        .en         (state_q == IDLE),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            beat_cnt_q   <= '0;
            addr_q       <= '0;
            wline_q      <= '0;
            line_q       <= '0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            wline_q      <= wline_d;
            line_q       <= line_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
        end
    end

    // A D-side grant with write asserted always becomes a writeback, even if read is also high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    state_d = dcache_write ? WR_DATA : RD_REQ;
                end else if (grant[0]) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ:  state_d = RD_DATA;
            RD_DATA: if (bmem_resp && beat_last) state_d = DONE;
            WR_DATA: if (beat_last) state_d = WR_WAIT;
            WR_WAIT: if (bmem_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        wline_d      = wline_q;
        line_d       = line_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        if (state_q == IDLE) begin
            beat_cnt_d = '0;
            if (grant[1]) begin
                last_grant_d = GNT_D;
                addr_d       = line_align(dcache_addr);
                if (dcache_write) wline_d = dcache_wdata;
            end else if (grant[0]) begin
                last_grant_d = GNT_I;
                addr_d       = line_align(icache_addr);
            end
        end
        if (state_q == RD_DATA && bmem_resp) begin
            line_d[BEAT_WIDTH*beat_cnt_q +: BEAT_WIDTH] = bmem_rdata;
            beat_cnt_d = beat_cnt_q + 1'b1;
            // Client-visible line only changes once the whole burst has arrived.
            if (beat_last) begin
                if (last_grant_q == GNT_I) irdata_d = line_d;
                else                       drdata_d = line_d;
            end
        end
        if (state_q == WR_DATA) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bmem_read   = (state_q == RD_REQ);
        bmem_write  = (state_q == WR_DATA);
        bmem_wdata  = '0;
        if (state_q == WR_DATA) begin
            bmem_wdata = wline_q[BEAT_WIDTH*beat_cnt_q +: BEAT_WIDTH];
        end
        icache_resp = (state_q == DONE) && (last_grant_q == GNT_I);
        dcache_resp = (state_q == DONE) && (last_grant_q == GNT_D);
    end

    assign bmem_address = addr_q;
    assign icache_rdata = irdata_q;
    assign dcache_rdata = drdata_q;

    a_dcache_rw_conflict: assert property (@(posedge clk) disable iff (rst)
        !(state_q == IDLE && dcache_read && dcache_write))
        else $warning("bmem_line_arbiter: dcache_read and dcache_write both high, write takes priority");

    a_bmem_resp_unexpected: assert property (@(posedge clk) disable iff (rst)
        !(bmem_resp && (state_q == IDLE || state_q == RD_REQ || state_q == DONE || state_q == WR_DATA)))
        else $warning("bmem_line_arbiter: bmem_resp outside a data phase is ignored");

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter; bmem is modelled by the stimulus sequence itself.
module tb_bmem_line_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_addr;
    logic         icache_read;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic [31:0]  dcache_addr;
    logic         dcache_read;
    logic         dcache_write;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic [31:0]  bmem_address;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic [63:0]  bmem_rdata;
    logic         bmem_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bmem_line_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .icache_addr  (icache_addr),
        .icache_read  (icache_read),
        .icache_rdata (icache_rdata),
        .icache_resp  (icache_resp),
        .dcache_addr  (dcache_addr),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_resp  (dcache_resp),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bmem_read"},    bmem_read,    0);
        check({tag, "_bmem_write"},   bmem_write,   0);
        check({tag, "_bmem_address"}, bmem_address, 0);
        check({tag, "_bmem_wdata"},   bmem_wdata,   0);
        check({tag, "_icache_resp"},  icache_resp,  0);
        check({tag, "_dcache_resp"},  dcache_resp,  0);
        check({tag, "_icache_rdata"}, icache_rdata, 0);
        check({tag, "_dcache_rdata"}, dcache_rdata, 0);
    endtask

    // Waits for the read command, then plays beats seed+k*step with the given resp pattern.
    task automatic serve_read(input logic is_i, input logic [31:0] exp_addr, input logic [63:0] seed,
                              input logic [63:0] step, input logic [7:0] pat, input int plen,
                              input string tag);
        int n = 0;
        int k = 0;
        logic [255:0] exp_line;
        while (!bmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bmem_read"}, bmem_read, 1);
        check({tag, "_addr"}, bmem_address, exp_addr);
        for (int c = 0; c < plen && k < 4; c++) begin
            @(negedge clk);
            check({tag, "_read_1cyc"}, bmem_read, 0);
            check({tag, "_early_resp"}, is_i ? icache_resp : dcache_resp, 0);
            bmem_resp  = pat[c];
            bmem_rdata = pat[c] ? seed + step * 64'(k) : 64'hDEAD_BEEF_0BAD_F00D;
            if (pat[c]) k++;
        end
        @(negedge clk);
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        for (int b = 0; b < 4; b++) exp_line[64*b +: 64] = seed + step * 64'(b);
        finish_resp(is_i, exp_line, 1'b1, tag);
    endtask

    // Expects resp now (first cycle after the last beat / write ack), then one cycle later low.
    task automatic finish_resp(input logic is_i, input logic [255:0] exp_line, input logic chk_line,
                               input string tag);
        check({tag, "_resp"},  is_i ? icache_resp : dcache_resp, 1);
        check({tag, "_other"}, is_i ? dcache_resp : icache_resp, 0);
        if (chk_line) check({tag, "_rdata"}, is_i ? icache_rdata : dcache_rdata, exp_line);
        @(negedge clk);
        check({tag, "_resp_1cyc"}, is_i ? icache_resp : dcache_resp, 0);
        if (is_i) begin
            icache_read = 1'b0;
        end else begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
        end
    endtask

    task automatic run_write(input logic [31:0] exp_addr, input logic [255:0] wline, input string tag);
        int n = 0;
        while (!bmem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bmem_write"}, bmem_write, 1);
        // Client inputs changing mid-burst must not disturb the latched transaction.
        dcache_addr  = 32'hFFFF_FFE0;
        dcache_wdata = ~wline;
        for (int k = 0; k < 4; k++) begin
            check({tag, "_wr_vld"},  bmem_write,   1);
            check({tag, "_wdata"},   bmem_wdata,   wline[64*k +: 64]);
            check({tag, "_waddr"},   bmem_address, exp_addr);
            check({tag, "_no_read"}, bmem_read,    0);
            @(negedge clk);
        end
        check({tag, "_wr_end"}, bmem_write, 0);
        repeat (4) begin
            check({tag, "_early_resp"}, dcache_resp, 0);
            @(negedge clk);
        end
        bmem_resp = 1'b1;
        @(negedge clk);
        bmem_resp = 1'b0;
        finish_resp(1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        rst          = 1'b1;
        icache_addr  = '0;
        icache_read  = 1'b0;
        dcache_addr  = '0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        dcache_wdata = '0;
        bmem_rdata   = '0;
        bmem_resp    = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single I-cache read, address aligned down to 0x40
        @(negedge clk);
        icache_addr = 32'h0000_0044;
        icache_read = 1'b1;
        serve_read(1'b1, 32'h0000_0040, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111,
                   8'h0F, 4, "t1");

        // 2: D-cache writeback, beats A,B,C,D in ascending order
        @(negedge clk);
        dcache_addr  = 32'h8000_0020;
        dcache_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        dcache_write = 1'b1;
        run_write(32'h8000_0020, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, "t2");

        // 3: contention after reset: D first, then I; then D alone; then both again -> I first
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        icache_addr = 32'h0000_1000;
        dcache_addr = 32'h0000_2040;
        icache_read = 1'b1;
        dcache_read = 1'b1;
        serve_read(1'b0, 32'h0000_2040, 64'h0D00_0000_0000_0001, 64'h10, 8'h0F, 4, "t3a_d");
        serve_read(1'b1, 32'h0000_1000, 64'h0100_0000_0000_0001, 64'h10, 8'h0F, 4, "t3a_i");
        @(negedge clk);
        dcache_addr = 32'h0000_3000;
        dcache_read = 1'b1;
        serve_read(1'b0, 32'h0000_3000, 64'h0D00_0000_0000_0002, 64'h10, 8'h0F, 4, "t3b_d");
        @(negedge clk);
        icache_addr = 32'h0000_4000;
        dcache_addr = 32'h0000_5000;
        icache_read = 1'b1;
        dcache_read = 1'b1;
        serve_read(1'b1, 32'h0000_4000, 64'h0100_0000_0000_0003, 64'h10, 8'h0F, 4, "t3c_i");
        serve_read(1'b0, 32'h0000_5000, 64'h0D00_0000_0000_0003, 64'h10, 8'h0F, 4, "t3c_d");

        // 4: beats arriving with gaps 1,0,0,1,0,1,1
        @(negedge clk);
        icache_addr = 32'h0000_00FF;
        icache_read = 1'b1;
        serve_read(1'b1, 32'h0000_00E0, 64'hCAFE_0000_0000_0000, 64'h0000_1111_0000_0001,
                   8'h69, 7, "t4");

        // 5: asynchronous reset in the middle of RD_DATA beat 2
        @(negedge clk);
        icache_addr = 32'h0000_0200;
        icache_read = 1'b1;
        @(negedge clk);
        check("t5_bmem_read", bmem_read, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bmem_resp  = 1'b1;
            bmem_rdata = 64'h5555_0000_0000_0000 + 64'(k);
        end
        check("t5_addr_before_rst", bmem_address, 32'h0000_0200);
        #1;
        rst       = 1'b1;
        bmem_resp = 1'b0;
        #1;
        check_all_zero("t5_async");
        icache_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        icache_addr = 32'h0000_0300;
        icache_read = 1'b1;
        serve_read(1'b1, 32'h0000_0300, 64'h7777_0000_0000_0010, 64'h3, 8'h0F, 4, "t5_after");

        // 6: D read and write together -> writeback only; read-line output untouched
        @(negedge clk);
        dcache_addr  = 32'h0000_0460;
        dcache_wdata = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                        64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        dcache_read  = 1'b1;
        dcache_write = 1'b1;
        run_write(32'h0000_0460, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                  64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, "t6");
        check("t6_dcache_rdata_kept", dcache_rdata, 0);
        @(negedge clk);
        check("t6_idle_no_read", bmem_read, 0);
        check("t6_idle_no_resp", dcache_resp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
